mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//   Shares the single-port memory engine between instruction fetch (IFU) and the load/store buffer (LSB).
//   Holds one transaction in flight at a time; the LSB has priority, bounded by a starvation limit.
//   Discards a fetch that is in flight when a pipeline flush arrives.
//   Sits between IFU/LSB and the byte-serial memory controller; all outputs are registered.
// PARAMETERS
//   STARVE_LIMIT  4  consecutive LSB grants, taken while ifu_req is high, after which IFU wins once (1..15)
// PORTS
//   clk        in   1   system clock
//   rst        in   1   synchronous active-high reset
//   rdy        in   1   global enable; low = freeze all state and outputs
//   flush      in   1   misprediction flush; cancels any pending or in-flight fetch
//   ifu_req    in   1   fetch request, held high until ifu_ack
//   ifu_addr   in   32  fetch address
//   ifu_ack    out  1   one-cycle pulse; ifu_ins is valid in the same cycle
//   ifu_ins    out  32  fetched word, held until the next ifu_ack
//   lsb_req    in   1   data request, held high until lsb_ack
//   lsb_we     in   1   1 = store, 0 = load
//   lsb_signed in   1   sign-extend the load (LB/LH)
//   lsb_size   in   2   0 = byte, 1 = half, 3 = word
//   lsb_addr   in   32  data address
//   lsb_wdata  in   32  store data
//   lsb_ack    out  1   one-cycle pulse; for loads, lsb_rdata is valid in the same cycle
//   lsb_rdata  out  32  load result, held until the next lsb_ack
//   mc_valid   out  1   one-cycle request pulse to the memory engine
//   mc_we      out  1   latched request fields; mc_we/mc_signed/mc_size/mc_addr/mc_wdata stable from mc_valid until mc_done
//   mc_signed  out  1   latched sign-extend flag (see mc_we)
//   mc_size    out  2   latched access size (see mc_we)
//   mc_addr    out  32  latched address (see mc_we)
//   mc_wdata   out  32  latched store data (see mc_we)
//   mc_done    in   1   one-cycle completion pulse from the engine
//   mc_rdata   in   32  read data, valid when mc_done is high
// BEHAVIOUR
//   Reset: state = IDLE, starve_cnt = 0, every output = 0.
//   rdy low: no state, counter or output changes; rdy low wins over all other inputs except rst.
//   States:
//     IDLE    -> BUSY_D on LSB grant; -> BUSY_I on IFU grant.
//     BUSY_D  wait for mc_done; then lsb_ack<=1, lsb_rdata<=mc_rdata (loads only), -> IDLE.
//     BUSY_I  wait for mc_done; then ifu_ack<=1, ifu_ins<=mc_rdata, -> IDLE.
//             flush while in BUSY_I -> DRAIN.
//     DRAIN   wait for mc_done; discard the data, no ack, -> IDLE.
//   Grant (evaluated in IDLE only):
//     A requester whose ack is high this cycle is masked; its req is still high from the last transaction.
//     ifu_req is ignored in any cycle where flush is high.
//     If both requesters are eligible: LSB wins unless starve_cnt == STARVE_LIMIT.
//   Starve counter:
//     starve_cnt increments on an LSB grant while ifu_req is high and flush is low; saturates at STARVE_LIMIT.
//     starve_cnt clears on an IFU grant or on flush.
//   Issue: on the grant edge, mc_valid<=1 and the mc_* fields are loaded from the winner.
//     mc_valid<=0 on the next edge; the fields hold until the transaction completes.
//     For IFU grants: mc_we=0, mc_size=3, mc_signed=0.
//   Completion:
//     mc_done is sampled only in BUSY_D/BUSY_I/DRAIN; mc_done in IDLE is ignored.
//     Ack is visible the cycle after mc_done and is cleared on the following edge.
//   Back-to-back:
//     A new grant may occur in the same cycle an ack is high, for the other requester only.
//     Minimum request-to-request spacing for one requester: mc_valid, done, ack, IDLE regrant.
//   Flush in the same cycle as mc_done in BUSY_I: the data is discarded, no ifu_ack.
//   Flush in BUSY_D or IDLE: no effect on LSB traffic.
//   Reset mid-transaction: the transaction is abandoned, no ack.
//     The memory engine is reset by the same rst.
// TESTING
//   1. Lone load: lsb_req, addr 0x1000, size 0; mc_done with mc_rdata 0xFFFFFF80 4 cycles later.
//      -> exactly one mc_valid; lsb_ack 1 cycle after mc_done; lsb_rdata=0xFFFFFF80; ifu_ack stays 0.
//   2. Simultaneous ifu_req and lsb_req in IDLE.
//      -> LSB granted first, IFU granted in the lsb_ack cycle; mc_addr sequence is lsb_addr then ifu_addr.
//   3. Starvation: lsb_req held with back-to-back stores, ifu_req high, STARVE_LIMIT=4.
//      -> exactly 4 LSB grants, then an IFU grant, then starve_cnt=0.
//   4. Flush 2 cycles after an IFU grant; mc_done with 0x00000013.
//      -> no ifu_ack; state IDLE one cycle after mc_done; the next fetch gets a fresh mc_valid.
//   5. rdy held low for 3 cycles while in BUSY_I, with mc_done pulsed during the stall.
//      -> no outputs change and the done pulse is ignored; the transaction completes only on a done pulse while rdy is high.
//   6. rst asserted while in BUSY_D.
//      -> next cycle all outputs are 0, state IDLE, and no lsb_ack is ever produced for that request.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares a single-port memory engine between instruction fetch (IFU)
// and the load/store buffer (LSB), with one transaction in flight at a time.
// LSB has priority. After STARVE_LIMIT consecutive LSB grants taken while IFU was
// waiting, the IFU wins once. A flush discards an in-flight fetch. All outputs are registered.
//
// Ports:
//   clk, rst (sync active-high), rdy (global enable; low freezes everything but rst)
//   flush                                    - cancels pending/in-flight fetch
//   ifu_req/ifu_addr -> ifu_ack/ifu_ins      - fetch side
//   lsb_req/we/signed/size/addr/wdata -> lsb_ack/lsb_rdata - data side
//   mc_valid/we/signed/size/addr/wdata -> engine, mc_done/mc_rdata <- engine
module mem_req_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ack,
  output logic [31:0] ifu_ins,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic        lsb_signed,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ack,
  output logic [31:0] lsb_rdata,
  output logic        mc_valid,
  output logic        mc_we,
  output logic        mc_signed,
  output logic [1:0]  mc_size,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic        mc_done,
  input  logic [31:0] mc_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        ifu_ack_q, ifu_ack_d;
  logic [31:0] ifu_ins_q, ifu_ins_d;
  logic        lsb_ack_q, lsb_ack_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic        mc_valid_q, mc_valid_d;
  logic        mc_we_q, mc_we_d;
  logic        mc_signed_q, mc_signed_d;
  logic [1:0]  mc_size_q, mc_size_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [31:0] mc_wdata_q, mc_wdata_d;

  // A requester whose ack is showing still has its req high from the
  // transaction just finished, so it must not be regranted this cycle.
  logic lsb_elig, ifu_elig, grant_lsb, grant_ifu;

  always_comb begin
    lsb_elig  = lsb_req & ~lsb_ack_q;
    ifu_elig  = ifu_req & ~ifu_ack_q & ~flush;
    grant_lsb = 1'b0;
    grant_ifu = 1'b0;
    if (state_q == IDLE) begin
      if (lsb_elig && ifu_elig) begin
        if (starve_q == LIMIT) grant_ifu = 1'b1;
        else                   grant_lsb = 1'b1;
      end else begin
        grant_lsb = lsb_elig;
        grant_ifu = ifu_elig;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    ifu_ack_d   = 1'b0;
    ifu_ins_d   = ifu_ins_q;
    lsb_ack_d   = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    mc_valid_d  = 1'b0;
    mc_we_d     = mc_we_q;
    mc_signed_d = mc_signed_q;
    mc_size_d   = mc_size_q;
    mc_addr_d   = mc_addr_q;
    mc_wdata_d  = mc_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_lsb) begin
          state_d     = BUSY_D;
          mc_valid_d  = 1'b1;
          mc_we_d     = lsb_we;
          mc_signed_d = lsb_signed;
          mc_size_d   = lsb_size;
          mc_addr_d   = lsb_addr;
          mc_wdata_d  = lsb_wdata;
          // Count only grants the IFU actually lost; saturate at the limit.
          if (ifu_req && !flush && starve_q != LIMIT) starve_d = starve_q + 4'd1;
        end else if (grant_ifu) begin
          state_d     = BUSY_I;
          mc_valid_d  = 1'b1;
          mc_we_d     = 1'b0;
          mc_signed_d = 1'b0;
          mc_size_d   = 2'd3;
          mc_addr_d   = ifu_addr;
          mc_wdata_d  = 32'd0;
          starve_d    = 4'd0;
        end
      end
      BUSY_D: begin
        if (mc_done) begin
          state_d   = IDLE;
          lsb_ack_d = 1'b1;
          if (!mc_we_q) lsb_rdata_d = mc_rdata;
        end
      end
      BUSY_I: begin
        if (mc_done) begin
          state_d = IDLE;
          // A flush coinciding with completion still drops the fetched word.
          if (!flush) begin
            ifu_ack_d = 1'b1;
            ifu_ins_d = mc_rdata;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mc_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) starve_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      ifu_ack_q   <= 1'b0;
      ifu_ins_q   <= 32'd0;
      lsb_ack_q   <= 1'b0;
      lsb_rdata_q <= 32'd0;
      mc_valid_q  <= 1'b0;
      mc_we_q     <= 1'b0;
      mc_signed_q <= 1'b0;
      mc_size_q   <= 2'd0;
      mc_addr_q   <= 32'd0;
      mc_wdata_q  <= 32'd0;
    end else if (rdy) begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      ifu_ack_q   <= ifu_ack_d;
      ifu_ins_q   <= ifu_ins_d;
      lsb_ack_q   <= lsb_ack_d;
      lsb_rdata_q <= lsb_rdata_d;
      mc_valid_q  <= mc_valid_d;
      mc_we_q     <= mc_we_d;
      mc_signed_q <= mc_signed_d;
      mc_size_q   <= mc_size_d;
      mc_addr_q   <= mc_addr_d;
      mc_wdata_q  <= mc_wdata_d;
    end
  end

  assign ifu_ack   = ifu_ack_q;
  assign ifu_ins   = ifu_ins_q;
  assign lsb_ack   = lsb_ack_q;
  assign lsb_rdata = lsb_rdata_q;
  assign mc_valid  = mc_valid_q;
  assign mc_we     = mc_we_q;
  assign mc_signed = mc_signed_q;
  assign mc_size   = mc_size_q;
  assign mc_addr   = mc_addr_q;
  assign mc_wdata  = mc_wdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: inputs change 1 time unit after each rising
// edge, and outputs are checked at that same point, so they reflect the edge just taken.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        ifu_req, ifu_ack;
  logic [31:0] ifu_addr, ifu_ins;
  logic        lsb_req, lsb_we, lsb_signed, lsb_ack;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic        mc_valid, mc_we, mc_signed, mc_done;
  logic [1:0]  mc_size;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY_D = 2'd1, S_BUSY_I = 2'd2, S_DRAIN = 2'd3;

  mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack), .ifu_ins(ifu_ins),
    .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_signed(lsb_signed), .lsb_size(lsb_size),
    .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_ack(lsb_ack), .lsb_rdata(lsb_rdata),
    .mc_valid(mc_valid), .mc_we(mc_we), .mc_signed(mc_signed), .mc_size(mc_size),
    .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st();
    logic [1:0] s;
    s = dut.state_q;
    return {30'd0, s};
  endfunction

  function automatic logic [31:0] sc();
    logic [3:0] s;
    s = dut.starve_q;
    return {28'd0, s};
  endfunction

  initial begin
    rst = 1; rdy = 1; flush = 0;
    ifu_req = 0; ifu_addr = 0;
    lsb_req = 0; lsb_we = 0; lsb_signed = 0; lsb_size = 0; lsb_addr = 0; lsb_wdata = 0;
    mc_done = 0; mc_rdata = 0;
    tick(); tick();
    chk("rst_state", st(), S_IDLE);
    chk("rst_starve", sc(), 0);
    chk("rst_outs", {ifu_ack, lsb_ack, mc_valid, mc_we, mc_signed}, 0);
    chk("rst_data", ifu_ins | lsb_rdata | mc_addr | mc_wdata | {30'd0, mc_size}, 0);
    rst = 0;

    // 1: lone signed byte load
    lsb_req = 1; lsb_addr = 32'h1000; lsb_size = 2'd0; lsb_signed = 1; lsb_we = 0;
    tick();
    chk("t1_valid", mc_valid, 1);
    chk("t1_addr", mc_addr, 32'h1000);
    chk("t1_fields", {mc_we, mc_signed, mc_size}, 4'b0100);
    chk("t1_state", st(), S_BUSY_D);
    tick();
    chk("t1_valid_drop", mc_valid, 0);
    tick(); tick();
    chk("t1_hold", mc_addr, 32'h1000);
    mc_done = 1; mc_rdata = 32'hFFFF_FF80;
    tick();
    chk("t1_ack", lsb_ack, 1);
    chk("t1_rdata", lsb_rdata, 32'hFFFF_FF80);
    chk("t1_state_idle", st(), S_IDLE);
    mc_done = 0; lsb_req = 0;
    tick();
    chk("t1_ack_clr", {lsb_ack, ifu_ack, mc_valid}, 0);
    chk("t1_rdata_hold", lsb_rdata, 32'hFFFF_FF80);

    // 2: simultaneous requests, LSB first, IFU in the lsb_ack cycle
    ifu_req = 1; ifu_addr = 32'h2000;
    lsb_req = 1; lsb_addr = 32'h3000; lsb_we = 1; lsb_wdata = 32'hDEAD_BEEF; lsb_size = 2'd3; lsb_signed = 0;
    tick();
    chk("t2_first_addr", mc_addr, 32'h3000);
    chk("t2_first_we", {mc_valid, mc_we}, 2'b11);
    chk("t2_wdata", mc_wdata, 32'hDEAD_BEEF);
    chk("t2_starve1", sc(), 1);
    mc_done = 1; mc_rdata = 32'h5A5A_5A5A;
    tick();
    chk("t2_lsb_ack", lsb_ack, 1);
    chk("t2_store_no_rdata", lsb_rdata, 32'hFFFF_FF80);
    mc_done = 0; lsb_req = 0;
    tick();
    chk("t2_second_addr", mc_addr, 32'h2000);
    chk("t2_ifu_fields", {mc_valid, mc_we, mc_signed, mc_size}, 5'b10011);
    chk("t2_state", st(), S_BUSY_I);
    chk("t2_starve0", sc(), 0);
    mc_done = 1; mc_rdata = 32'h1234_5678;
    tick();
    chk("t2_ifu_ack", ifu_ack, 1);
    chk("t2_ifu_ins", ifu_ins, 32'h1234_5678);
    mc_done = 0; ifu_req = 0;
    tick();
    chk("t2_ifu_ack_clr", ifu_ack, 0);

    // 3: starvation; ifu_req dropped only in lsb_ack cycles so LSB keeps winning
    ifu_addr = 32'h5000; lsb_addr = 32'h4000; lsb_we = 1;
    lsb_req = 1; ifu_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_grant%0d_addr", i), mc_addr, 32'h4000);
      chk($sformatf("t3_grant%0d_starve", i), sc(), i + 1);
      mc_done = 1;
      tick();
      chk($sformatf("t3_ack%0d", i), lsb_ack, 1);
      mc_done = 0; ifu_req = 0;
      tick();
      chk($sformatf("t3_gap%0d", i), mc_valid, 0);
      ifu_req = 1;
    end
    tick();
    chk("t3_ifu_wins", mc_addr, 32'h5000);
    chk("t3_state", st(), S_BUSY_I);
    chk("t3_starve_clr", sc(), 0);
    lsb_req = 0;
    mc_done = 1; mc_rdata = 32'h5555_AAAA;
    tick();
    chk("t3_ifu_ack", ifu_ack, 1);
    mc_done = 0; ifu_req = 0;
    tick();

    // 4: flush two cycles after an IFU grant
    ifu_req = 1; ifu_addr = 32'h6000;
    tick();
    chk("t4_grant", mc_addr, 32'h6000);
    ifu_req = 0;
    tick();
    flush = 1;
    tick();
    chk("t4_drain", st(), S_DRAIN);
    flush = 0;
    mc_done = 1; mc_rdata = 32'h0000_0013;
    tick();
    chk("t4_idle", st(), S_IDLE);
    chk("t4_no_ack", ifu_ack, 0);
    chk("t4_ins_kept", ifu_ins, 32'h5555_AAAA);
    mc_done = 0; ifu_req = 1; ifu_addr = 32'h6100;
    tick();
    chk("t4_fresh_valid", mc_valid, 1);
    chk("t4_fresh_addr", mc_addr, 32'h6100);
    mc_done = 1; mc_rdata = 32'hAAAA_5555;
    tick();
    chk("t4_ack", ifu_ack, 1);
    chk("t4_ins", ifu_ins, 32'hAAAA_5555);
    mc_done = 0; ifu_req = 0;
    tick();

    // 5: rdy low for 3 cycles in BUSY_I with mc_done pulsed during the stall
    ifu_req = 1; ifu_addr = 32'h7000;
    tick();
    chk("t5_grant", mc_valid, 1);
    rdy = 0; mc_done = 1; mc_rdata = 32'hBBBB_BBBB;
    tick();
    mc_done = 0;
    tick(); tick();
    chk("t5_frozen_valid", mc_valid, 1);
    chk("t5_frozen_state", st(), S_BUSY_I);
    chk("t5_no_ack", ifu_ack, 0);
    chk("t5_ins", ifu_ins, 32'hAAAA_5555);
    rdy = 1;
    tick();
    chk("t5_resume_valid", mc_valid, 0);
    chk("t5_still_busy", st(), S_BUSY_I);
    mc_done = 1; mc_rdata = 32'h0BAD_F00D;
    tick();
    chk("t5_ack", ifu_ack, 1);
    chk("t5_ins_new", ifu_ins, 32'h0BAD_F00D);
    mc_done = 0; ifu_req = 0;
    tick();

    // 6: reset in BUSY_D abandons the load
    lsb_req = 1; lsb_we = 0; lsb_addr = 32'h8000;
    tick();
    chk("t6_busy", st(), S_BUSY_D);
    rst = 1;
    tick();
    chk("t6_rst_state", st(), S_IDLE);
    chk("t6_rst_outs", {ifu_ack, lsb_ack, mc_valid, mc_we, mc_signed}, 0);
    chk("t6_rst_data", ifu_ins | lsb_rdata | mc_addr, 0);
    rst = 0; lsb_req = 0; mc_done = 1; mc_rdata = 32'hCCCC_CCCC;
    tick();
    chk("t6_done_ignored", {lsb_ack, mc_valid}, 0);
    chk("t6_rdata_zero", lsb_rdata, 0);
    mc_done = 0;
    tick();
    chk("t6_never_ack", lsb_ack, 0);

    // 7: flush on the same cycle as mc_done in BUSY_I
    ifu_req = 1; ifu_addr = 32'h9000;
    tick();
    ifu_req = 0;
    flush = 1; mc_done = 1; mc_rdata = 32'hEEEE_EEEE;
    tick();
    chk("t7_idle", st(), S_IDLE);
    chk("t7_no_ack", ifu_ack, 0);
    chk("t7_ins_kept", ifu_ins, 0);
    flush = 0; mc_done = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
